// File: rtl/booth_mac_acc.sv
// booth_mac_acc
// Accumulate stage that sits behind the 8x8 signed Booth multiplier. A job is
// opened with a one-cycle start pulse carrying a beat count; that many signed
// products are then summed into a saturating accumulator. The final sum is
// presented on a valid/ready output handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      one-cycle job request, honoured only while idle
//   len        beat count of the job, sampled with an honoured start
//   in_valid   product is valid this cycle
//   in_ready   stage accepts a product this cycle (decoded from state)
//   product    signed product from the multiplier
//   out_valid  acc_out holds the final job result (decoded from state)
//   out_ready  consumer takes the result
//   acc_out    signed accumulator value (running value outside DONE)
//   overflow   sticky saturation flag for the current/last job
//   busy       high while a job is accumulating or waiting to be read
module booth_mac_acc #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     overflow,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  // One extra bit of headroom: a single PROD_W-bit addend can push the sum
  // at most one bit past the accumulator range, so the top two bits of the
  // wide sum disagreeing is exactly the out-of-range condition.
  logic [ACC_W:0]   sum_wide;
  logic             clamp_pos;
  logic             clamp_neg;
  logic [ACC_W-1:0] sum_sat;
  logic             beat;

  assign sum_wide  = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
  assign clamp_pos = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
  assign clamp_neg =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];

  always_comb begin
    sum_sat = sum_wide[ACC_W-1:0];
    if (clamp_pos) begin
      sum_sat = ACC_MAX;
    end else if (clamp_neg) begin
      sum_sat = ACC_MIN;
    end
  end

  assign beat = in_valid && (state_q == S_ACCUM);

  // Next state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            count_d = len;
            state_d = S_ACCUM;
          end
        end
      end

      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (beat) begin
          acc_d   = sum_sat;
          count_d = count_q - LEN_W'(1);
          if (clamp_pos || clamp_neg) begin
            ovf_d = 1'b1;
          end
          if (count_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_booth_mac_acc.sv
// tb_booth_mac_acc
// Directed stimulus against booth_mac_acc. A job-level model (integer sum
// with clamping, beats remaining, result pending) predicts every output on
// every cycle; literal expected results pin the model on each job.
module tb_booth_mac_acc;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 20;
  localparam int LEN_W  = 8;
  localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] product;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  acc_out;
  logic                     overflow;
  logic                     busy;

  int n_checks = 0;
  int n_pass   = 0;

  booth_mac_acc #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .product  (product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level model ----------------
  bit     m_on     = 1'b0;
  bit     m_active = 1'b0;
  bit     m_done   = 1'b0;
  int     m_left   = 0;
  longint m_acc    = 0;
  bit     m_ovf    = 1'b0;

  function automatic longint clamp(input longint s);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on     <= 1'b1;
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_left   <= 0;
      m_acc    <= 0;
      m_ovf    <= 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_active) begin
      if (in_valid) begin
        m_acc <= clamp(m_acc + longint'(product));
        if (clamp(m_acc + longint'(product)) != m_acc + longint'(product))
          m_ovf <= 1'b1;
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end else if (start) begin
      m_acc <= 0;
      m_ovf <= 1'b0;
      if (len == 0) begin
        m_done <= 1'b1;
      end else begin
        m_active <= 1'b1;
        m_left   <= int'(len);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      check("cyc_in_ready",  longint'(in_ready),  longint'(m_active));
      check("cyc_out_valid", longint'(out_valid), longint'(m_done));
      check("cyc_busy",      longint'(busy),      longint'(m_active | m_done));
      check("cyc_acc_out",   longint'(acc_out),   m_acc);
      check("cyc_overflow",  longint'(overflow),  longint'(m_ovf));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int p);
    in_valid = 1'b1;
    product  = PROD_W'(p);
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the cycle that accepted the last beat: the result
  // must already be presented.
  task automatic finish_job(input string name, input longint exp_acc, input bit exp_ovf);
    check({name, "_latency"}, longint'(out_valid), 1);
    check({name, "_acc"},     longint'(acc_out),   exp_acc);
    check({name, "_ovf"},     longint'(overflow),  longint'(exp_ovf));
    $display("job %s: acc_out=%0d overflow=%0b", name, acc_out, overflow);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle_valid"}, longint'(out_valid), 0);
    check({name, "_idle_busy"},  longint'(busy),      0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    product   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready",  longint'(in_ready),  0);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_acc",       longint'(acc_out),   0);
    check("reset_ovf",       longint'(overflow),  0);
    check("reset_busy",      longint'(busy),      0);
    tick();

    // len=3 back-to-back
    start_job(3);
    beat(100);
    beat(-250);
    beat(7);
    finish_job("len3", -143, 1'b0);

    // len=4 with in_valid toggling
    start_job(4);
    beat(1000); tick();
    beat(2000); tick();
    beat(3000); tick();
    beat(4000);
    finish_job("toggle4", 10000, 1'b0);

    // positive saturation boundary
    start_job(17);
    repeat (17) beat(32767);
    finish_job("pos17", 524287, 1'b1);
    start_job(16);
    repeat (16) beat(32767);
    finish_job("pos16", 524272, 1'b0);

    // negative saturation boundary
    start_job(17);
    repeat (17) beat(-32768);
    finish_job("neg17", -524288, 1'b1);
    start_job(16);
    repeat (16) beat(-32768);
    finish_job("neg16", -524288, 1'b0);

    // len=0: straight to DONE, held with start pulses
    start_job(0);
    check("len0_valid", longint'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = LEN_W'(9);
      tick();
      start = 1'b0;
      check("len0_hold_valid", longint'(out_valid), 1);
      check("len0_hold_acc",   longint'(acc_out),   0);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    check("len0_release_valid", longint'(out_valid), 0);
    tick();
    check("len0_start_ignored", longint'(in_ready), 0);
    $display("job len0: result 0 held, start during DONE ignored");

    // reset mid-job, then a fresh job
    start_job(5);
    beat(50);
    beat(60);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready",  longint'(in_ready),  0);
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_acc",       longint'(acc_out),   0);
    check("abort_ovf",       longint'(overflow),  0);
    check("abort_busy",      longint'(busy),      0);
    $display("job abort: reset after 2 of 5 beats");
    tick();
    start_job(1);
    beat(-9);
    finish_job("fresh1", -9, 1'b0);

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_mac_acc.md
Name: booth_mac_acc

Overview:
- Sequential accumulate stage directly downstream of the combinational 8x8 signed Booth multiplier.
- Consumes a stream of signed 16-bit products over a valid/ready handshake.
- Sums a programmed number of products into a saturating signed accumulator, then presents the result on an output valid/ready handshake.
- Used for dot-product and FIR-tap style sums built on the multiplier.

Parameters:
- PROD_W, 16, width of the signed input product (matches the multiplier output).
- ACC_W, 20, width of the signed accumulator and result; must be > PROD_W.
- LEN_W, 8, width of the beat-count field (1..2^LEN_W-1 beats per job).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request; honoured only in IDLE.
- len  in  LEN_W  number of products in the job; sampled when start is honoured.
- in_valid  in  1  product is valid this cycle.
- in_ready  out  1  stage accepts a product this cycle.
- product  in  PROD_W  signed product from the multiplier.
- out_valid  out  1  acc_out holds the final job result.
- out_ready  in  1  consumer takes the result.
- acc_out  out  ACC_W  signed accumulated result.
- overflow  out  1  sticky flag: saturation occurred during the current/last job.
- busy  out  1  high in ACCUM and DONE.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE; acc=0; count=0;
  - in_ready=0; out_valid=0; acc_out=0; overflow=0; busy=0.
- Reset mid-job aborts the job with no partial output.
- States are IDLE, ACCUM and DONE. All outputs are registered or decoded from state only; there is no combinational path from in_valid/out_ready to any output.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 and len!=0: acc<=0, overflow<=0, count<=len, go to ACCUM.
  - start=1 and len==0: acc<=0, overflow<=0, go directly to DONE (result 0).
- ACCUM:
  - in_ready=1, busy=1.
  - A beat is accepted when in_valid & in_ready.
  - On a beat: acc <= sat(acc + sign_extend(product)) and count <= count-1.
  - If count==1 on that beat, go to DONE.
  - No beat means acc and count hold, with no timeout.
  - start is ignored.
- DONE:
  - out_valid=1, acc_out=acc, in_ready=0.
  - Holds until out_ready=1, then goes to IDLE the next cycle; out_valid drops in that same cycle.
  - start is ignored, including when it coincides with out_ready.
  - A new job needs a start in IDLE, so there is at least one idle cycle between jobs.
- Arithmetic:
  - The sum is computed at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1 it clamps to that value; below -2^(ACC_W-1) it clamps to that value.
  - Any clamp sets overflow, which stays set until the next honoured start or rst.
  - Once saturated, later beats keep accumulating from the clamped value; there is no wrap-around.
- Latency:
  - out_valid rises the cycle after the last beat is accepted.
  - Minimum job time is len cycles plus one cycle in DONE.
- acc_out is only meaningful when out_valid=1. Outside DONE it shows the running acc.

Test Plan:
- Reset, then start with len=3 and products +100, -250, +7 back-to-back -> out_valid one cycle after the 3rd beat, acc_out=-143, overflow=0. out_ready=1 -> IDLE next cycle.
- len=4 with in_valid toggling 1,0,1,0,... and products 1000, 2000, 3000, 4000 -> only 4 beats are accepted, acc_out=10000, and in_ready stays high until the 4th accepted beat.
- len=17 with all products 32767 -> acc_out=524287 (clamped), overflow=1. Same test with 16 beats -> 524272, overflow=0.
- len=17 with all products -32768 -> acc_out=-524288, overflow=1. Same test with 16 beats -> -524288, overflow=0 (exact boundary, no clamp).
- start with len=0 -> DONE the next cycle with acc_out=0. Holding out_ready=0 for 5 cycles keeps out_valid=1 and acc_out stable. Pulsing start during DONE has no effect.
- rst asserted after 2 of 5 beats (products 50, 60) -> all outputs are 0 the next cycle. A fresh job with len=1 and product -9 gives acc_out=-9, with no carry-over from the aborted job.
